// File: rtl/mult_adder_seq_pkg.sv
// Shared widths, state encoding and lane addressing for the lane-serial dot-product engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mult_adder_seq_pkg;

  localparam int OPR_W  = 8;
  localparam int NLANES = 128;
  localparam int LANE_W = 7;
  localparam int PROD_W = 16;
  localparam int SUM_W  = 15;
  localparam int MAG_W  = 14;
  localparam int ACC_W  = 22;
  localparam int VEC_W  = NLANES * OPR_W;
  localparam logic [MAG_W-1:0] MAG_MAX = 14'h3FFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Bit offset of a lane's 8-bit operand inside a packed 1024-bit vector.
  function automatic logic [9:0] lane_lsb(input logic [LANE_W-1:0] lane);
    return {lane, 3'b000};
  endfunction

endpackage

// File: rtl/float8_lane_mul.sv
// One lane of the multiply: two sign-magnitude bytes to a two's-complement product.
// Latency: combinational.
// Backpressure: none.
module float8_lane_mul
  import mult_adder_seq_pkg::*;
(
  input  logic [OPR_W-1:0]         a_i,
  input  logic [OPR_W-1:0]         b_i,
  output logic signed [PROD_W-1:0] prod_o
);

  logic [MAG_W-1:0] mag;
  logic             neg;

  assign mag = MAG_W'(a_i[6:0]) * MAG_W'(b_i[6:0]);
  // A zero magnitude is always +0, so -0 operands never produce a negative term.
  assign neg = (a_i[7] ^ b_i[7]) && (mag != '0);

  // Widen to signed and negate when the product sign is set.
  always_comb begin
    prod_o = $signed({2'b00, mag});
    if (neg) prod_o = -$signed({2'b00, mag});
  end

endmodule

// File: rtl/mult_adder_seq.sv
// Lane-serial 128-lane sign-magnitude dot product, LANES products accumulated per cycle.
// Latency: done pulses NLANES/LANES+1 cycles after the start edge (17 at LANES=8).
// Backpressure: start is only sampled in IDLE; requests while busy are dropped.
module mult_adder_seq
  import mult_adder_seq_pkg::*;
#(
  parameter int LANES = 8
) (
  input  logic             clk,
  input  logic             iRst_n,
  input  logic             start,
  input  logic [VEC_W-1:0] opr1,
  input  logic [VEC_W-1:0] opr2,
  output logic             busy,
  output logic             done,
  output logic [SUM_W-1:0] sum,
  output logic             overflow
);

  localparam int NBEATS = NLANES / LANES;
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  state_t                    state_q;
  logic [BEAT_W-1:0]         beat_q;
  logic [VEC_W-1:0]          opa_q, opb_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic                      busy_q, done_q, ovf_q;
  logic [SUM_W-1:0]          sum_q;

  logic signed [PROD_W-1:0]  prod [LANES];
  logic signed [ACC_W-1:0]   beat_sum;
  logic [ACC_W-1:0]          acc_abs;
  logic [MAG_W-1:0]          mag_d;
  logic                      ovf_d;
  logic [SUM_W-1:0]          sum_d;

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [LANE_W-1:0] lane;
    assign lane = LANE_W'(32'(beat_q) * LANES + j);
    float8_lane_mul u_mul (
      .a_i    (opa_q[lane_lsb(lane) +: OPR_W]),
      .b_i    (opb_q[lane_lsb(lane) +: OPR_W]),
      .prod_o (prod[j])
    );
  end

  // Adder tree: sign-extend every lane product and sum this beat's contribution.
  always_comb begin
    beat_sum = '0;
    for (int j = 0; j < LANES; j++) begin
      beat_sum = beat_sum + ACC_W'(prod[j]);
    end
  end

  // Final conversion: two's complement to sign-magnitude with saturation; 0 stays +0.
  always_comb begin
    acc_abs = acc_q[ACC_W-1] ? ACC_W'(-acc_q) : acc_q;
    ovf_d   = |acc_abs[ACC_W-1:MAG_W];
    mag_d   = ovf_d ? MAG_MAX : acc_abs[MAG_W-1:0];
    sum_d   = {acc_q[ACC_W-1], mag_d};
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (!iRst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            opa_q   <= opr1;
            opb_q   <= opr2;
            acc_q   <= '0;
            beat_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= ACC;
          end
        end
        ACC: begin
          acc_q  <= acc_q + beat_sum;
          beat_q <= beat_q + BEAT_W'(1);
          if (beat_q == BEAT_W'(NBEATS - 1)) state_q <= FIN;
        end
        FIN: begin
          sum_q   <= sum_d;
          ovf_q   <= ovf_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_mult_adder_seq.sv
// Scoreboard bench for mult_adder_seq: expected results queued at start, checked on done.
// Latency: expects done NLANES/LANES+1 edges after the start edge.
// Backpressure: exercises ignored start while busy and mid-operation reset.
module tb_mult_adder_seq;

  localparam int LANES = 8;
  localparam int LAT   = 128 / LANES + 1;

  logic          clk = 1'b0;
  logic          iRst_n = 1'b0;
  logic          start = 1'b0;
  logic [1023:0] opr1 = '0;
  logic [1023:0] opr2 = '0;
  logic          busy, done, overflow;
  logic [14:0]   sum;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    logic [14:0] sum;
    logic        ovf;
    int          start_edge;
  } exp_t;
  exp_t sb_q[$];

  mult_adder_seq #(.LANES(LANES)) dut (
    .clk      (clk),
    .iRst_n   (iRst_n),
    .start    (start),
    .opr1     (opr1),
    .opr2     (opr2),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .overflow (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference dot product, independent of the DUT's lane/beat structure.
  task automatic model(input logic [1023:0] a, input logic [1023:0] b,
                       output logic [14:0] s, output logic o);
    int acc = 0;
    int mag;
    for (int i = 0; i < 128; i++) begin
      logic [7:0] x, y;
      x = a[i*8 +: 8];
      y = b[i*8 +: 8];
      mag = int'(x[6:0]) * int'(y[6:0]);
      acc += (x[7] ^ y[7]) ? -mag : mag;
    end
    mag = (acc < 0) ? -acc : acc;
    o = (mag > 16383);
    if (o) mag = 16383;
    s = {(acc < 0), 14'(mag)};
  endtask

  // Scoreboard: every done pops one expected result and checks value and latency.
  always @(negedge clk) begin
    if (iRst_n && done) begin
      if (sb_q.size() == 0) begin
        chk("spurious_done", {31'b0, done}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sum", {17'b0, sum}, {17'b0, e.sum});
        chk("overflow", {31'b0, overflow}, {31'b0, e.ovf});
        chk("latency", cyc - e.start_edge, LAT);
      end
    end
  end

  task automatic launch(input logic [1023:0] a, input logic [1023:0] b);
    exp_t e;
    model(a, b, e.sum, e.ovf);
    @(posedge clk); #1;
    opr1 = a; opr2 = b; start = 1'b1;
    e.start_edge = cyc + 1;
    sb_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Wait for done, checking busy every cycle of the operation.
  task automatic wait_done();
    int n = 0;
    forever begin
      @(negedge clk);
      if (done) break;
      chk("busy_during_op", {31'b0, busy}, 32'd1);
      n++;
      if (n > 3 * LAT) begin
        chk("done_timeout", {31'b0, done}, 32'd1);
        break;
      end
    end
    chk("busy_at_done", {31'b0, busy}, 32'd0);
    @(negedge clk);
    chk("done_one_cycle", {31'b0, done}, 32'd0);
  endtask

  task automatic run_op(input logic [1023:0] a, input logic [1023:0] b);
    launch(a, b);
    wait_done();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1023:0] a, b;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_sum", {17'b0, sum}, 32'd0);
    chk("rst_ovf", {31'b0, overflow}, 32'd0);
    iRst_n = 1'b1;

    // All zeros.
    run_op('0, '0);
    chk("zero_sum", {17'b0, sum}, 32'h0000);

    // Lane 0 and lane 127 max magnitude.
    a = '0; b = '0; a[7:0] = 8'h7F; b[7:0] = 8'h7F;
    run_op(a, b);
    chk("lane0_sum", {17'b0, sum}, 32'h3F01);
    a = '0; b = '0; a[127*8 +: 8] = 8'h7F; b[127*8 +: 8] = 8'h7F;
    run_op(a, b);
    chk("lane127_sum", {17'b0, sum}, 32'h3F01);

    // Mixed signs and a -0 operand: 15 - 20 + 0 = -5.
    a = '0; b = '0;
    a[7:0] = 8'h05;  b[7:0] = 8'h03;
    a[15:8] = 8'h85; b[15:8] = 8'h04;
    a[23:16] = 8'h80; b[23:16] = 8'h7F;
    run_op(a, b);
    chk("neg5_sum", {17'b0, sum}, 32'h4005);

    // Saturation both directions, then overflow must clear.
    a = {128{8'h7F}}; b = {128{8'h7F}};
    run_op(a, b);
    chk("sat_pos_sum", {17'b0, sum}, 32'h3FFF);
    chk("sat_pos_ovf", {31'b0, overflow}, 32'd1);
    a = {128{8'hFF}};
    run_op(a, b);
    chk("sat_neg_sum", {17'b0, sum}, 32'h7FFF);
    chk("sat_neg_ovf", {31'b0, overflow}, 32'd1);
    run_op('0, '0);
    chk("ovf_cleared", {31'b0, overflow}, 32'd0);

    // Random back-to-back operations.
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 32; i++) begin
        a[i*32 +: 32] = $urandom;
        b[i*32 +: 32] = $urandom;
      end
      run_op(a, b);
    end

    // Restart while busy and operand change mid-operation are ignored.
    a = '0; b = '0; a[7:0] = 8'h03; b[7:0] = 8'h02;
    launch(a, b);
    repeat (4) @(posedge clk);
    #1;
    opr1 = {128{8'h7F}}; opr2 = {128{8'h7F}}; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    chk("ignored_start_sum", {17'b0, sum}, 32'h0006);
    repeat (LAT + 3) @(negedge clk);
    chk("no_second_done", sb_q.size(), 0);

    // Reset mid-operation, then a fresh full-latency operation.
    a = {128{8'h7F}}; b = {128{8'h7F}};
    launch(a, b);
    repeat (6) @(posedge clk);
    #1;
    iRst_n = 1'b0;
    @(posedge clk); #1;
    sb_q.delete();
    @(negedge clk);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_sum", {17'b0, sum}, 32'd0);
    chk("midrst_ovf", {31'b0, overflow}, 32'd0);
    iRst_n = 1'b1;
    a = '0; b = '0; a[64*8 +: 8] = 8'h8A; b[64*8 +: 8] = 8'h0B;
    run_op(a, b);
    chk("post_rst_sum", {17'b0, sum}, 32'h406E);

    repeat (5) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
